vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator; successor to the fixed 640x480 horizontal sync counter.
- Generates horizontal and vertical counters, sync pulses with selectable polarity, active-video flag, and line/frame strobes.
- Includes an internal pixel-tick divider from the system clock.
- Sits between the 100 MHz system clock and the pixel/object renderer (paddle, ball, bricks).

Parameters:
- CLK_DIV, 4, system clocks per pixel tick (>=1)
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, h_sync active level (0 = active-low)
- VS_POL, 0, v_sync active level (0 = active-low)
- CW, 10, counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  in  1  system clock (100 MHz)
- reset_n  in  1  asynchronous active-low reset
- run  in  1  1 = timing advances; 0 = freeze all counters
- pix_tick  out  1  one-clk pixel enable
- h_sync  out  1  horizontal sync, polarity per HS_POL
- v_sync  out  1  vertical sync, polarity per VS_POL
- video_on  out  1  pixel_x < H_ACTIVE and pixel_y < V_ACTIVE
- pixel_x  out  CW  horizontal count, 0..H_TOTAL-1
- pixel_y  out  CW  vertical count, 0..V_TOTAL-1
- line_end  out  1  one-clk strobe on the last pixel of a line
- frame_end  out  1  one-clk strobe on the last pixel of a frame

Behaviour:
Derived constants:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800)
- V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525)

Reset (reset_n = 0, asynchronous):
- div counter, pixel_x, pixel_y all cleared to 0.
- Decoded outputs at reset: pix_tick 0 (for CLK_DIV>1), h_sync = ~HS_POL, v_sync = ~VS_POL, video_on 1, line_end 0, frame_end 0.
- Reset asserted mid-frame takes effect immediately and does not wait for a clock edge.

Divider:
- div counts 0..CLK_DIV-1 while run=1.
- pix_tick = run && (div == CLK_DIV-1), combinational from registered div.
- CLK_DIV=1: pix_tick = run.

Horizontal counter:
- On a clk edge with pix_tick=1: pixel_x increments; at H_TOTAL-1 it wraps to 0.

Vertical counter:
- Advances only on an edge where pix_tick=1 and pixel_x = H_TOTAL-1.
- Increments, wrapping V_TOTAL-1 -> 0.

Strobes:
- line_end = pix_tick && pixel_x == H_TOTAL-1.
- frame_end = line_end && pixel_y == V_TOTAL-1.
- Both are exactly one clk wide.

Sync decode (combinational from registered counters, no added latency):
- h_sync active while H_ACTIVE+H_FP <= pixel_x <= H_ACTIVE+H_FP+H_SYNC-1 (default 656..751).
- v_sync active while V_ACTIVE+V_FP <= pixel_y <= V_ACTIVE+V_FP+V_SYNC-1 (default 490..491).

run deasserted:
- div, pixel_x, pixel_y hold.
- pix_tick, line_end, frame_end forced to 0.
- Sync and video_on keep their decoded values.
- Reasserting run resumes from the held div value with no skipped or duplicated pixel.

Other rules:
- Simultaneous x wrap and y wrap in the same edge: both counters become 0.
- All arithmetic is unsigned in CW bits. Parameter sets where H_TOTAL or V_TOTAL exceeds 2^CW are illegal; flag with an elaboration-time check.

Optional Feature:
Macro: VGA_FRAME_CNT_EN
- Defined:
  - Adds output frame_cnt (16 bits, reset 0).
  - frame_cnt increments on each edge where frame_end=1 and wraps 65535 -> 0.
  - Adds input frame_cnt_clr (1 bit); frame_cnt_clr=1 synchronously clears to 0 and takes priority over increment.
- Not defined: neither port exists, no counter logic is built, and all other behaviour is identical.

Test Plan:
1. Defaults; assert reset_n=0 mid-frame (x=300, y=100) -> counters 0, h_sync=1, v_sync=1, video_on=1, pix_tick=0 with no clock edge needed.
2. Defaults, run=1 -> pix_tick every 4th clk; h_sync low exactly for x=656..751 (96 ticks = 384 clks); video_on low from x=640.
3. Defaults -> x 799->0 with y 0->1 on the same tick; line_end high one clk at x=799; at y=524,x=799 frame_end high one clk, then x=0,y=0; v_sync low for y=490..491 only.
4. CLK_DIV=1, H 4/1/2/1, V 3/1/1/1, HS_POL=1 -> pix_tick constant 1; line period 8 clks; h_sync high at x=5..6; frame period 48 clks.
5. Defaults; drop run at x=200 for 37 clks -> x, y, div frozen and strobes 0; after reassert, next tick arrives at the same div phase and x=201.
6. VGA_FRAME_CNT_EN defined -> after 3 frames frame_cnt=3; frame_cnt_clr pulsed on the frame_end clk -> frame_cnt=0, not 4.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with an internal pixel divider.
// Optional VGA_FRAME_CNT_EN adds a 16-bit frame counter with a synchronous clear.
`timescale 1ns/1ps
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          run,
`ifdef VGA_FRAME_CNT_EN
    input  logic          frame_cnt_clr,
    output logic [15:0]   frame_cnt,
`endif
    output logic          pix_tick,
    output logic          h_sync,
    output logic          v_sync,
    output logic          video_on,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y,
    output logic          line_end,
    output logic          frame_end
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [CW-1:0] H_VIS  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS  = CW'(V_ACTIVE);

    // Reject parameter sets that the counters cannot represent.
    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be >= 1");
    end
    if (H_TOTAL > (1 << CW)) begin : g_bad_h
        $error("vga_timing_gen: H_TOTAL does not fit in CW bits");
    end
    if (V_TOTAL > (1 << CW)) begin : g_bad_v
        $error("vga_timing_gen: V_TOTAL does not fit in CW bits");
    end
    if (H_SYNC < 1 || V_SYNC < 1) begin : g_bad_sync
        $error("vga_timing_gen: sync widths must be >= 1");
    end

    logic div_end;
    logic x_last;
    logic y_last;

    if (CLK_DIV > 1) begin : g_div
        localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
        logic [DW-1:0] div_q;

        // Pixel divider: free-runs 0..CLK_DIV-1 while run is high.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                div_q <= '0;
            end else if (run) begin
                if (div_q == DIV_LAST) begin
                    div_q <= '0;
                end else begin
                    div_q <= div_q + DW'(1);
                end
            end
        end

        assign div_end = (div_q == DIV_LAST);
    end else begin : g_nodiv
        assign div_end = 1'b1;
    end

    assign pix_tick = run & div_end;
    assign x_last   = (pixel_x == H_LAST);
    assign y_last   = (pixel_y == V_LAST);

    // Horizontal counter: one step per pixel tick, wraps at line end.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pixel_x <= '0;
        end else if (pix_tick) begin
            if (x_last) begin
                pixel_x <= '0;
            end else begin
                pixel_x <= pixel_x + CW'(1);
            end
        end
    end

    // Vertical counter: steps on the tick that ends a line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pixel_y <= '0;
        end else if (pix_tick && x_last) begin
            if (y_last) begin
                pixel_y <= '0;
            end else begin
                pixel_y <= pixel_y + CW'(1);
            end
        end
    end

    // Decode syncs, visibility and strobes straight from the counters.
    always_comb begin
        h_sync    = ~HS_POL;
        v_sync    = ~VS_POL;
        if (pixel_x >= HS_BEG && pixel_x <= HS_END) begin
            h_sync = HS_POL;
        end
        if (pixel_y >= VS_BEG && pixel_y <= VS_END) begin
            v_sync = VS_POL;
        end
        video_on  = (pixel_x < H_VIS) && (pixel_y < V_VIS);
        line_end  = pix_tick && x_last;
        frame_end = line_end && y_last;
    end

`ifdef VGA_FRAME_CNT_EN
    // Frame counter: clear wins over the end-of-frame increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt <= '0;
        end else if (frame_cnt_clr) begin
            frame_cnt <= '0;
        end else if (frame_end) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: default-timing and tiny-timing instances checked every
// cycle against a tick-count model, plus literal pins and random run gaps.
`timescale 1ns/1ps
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic run_a = 1'b1;
    logic run_b = 1'b1;

    always #5 clk = ~clk;

    logic       tick_a, hs_a, vs_a, vid_a, le_a, fe_a;
    logic [9:0] x_a, y_a;
    logic       tick_b, hs_b, vs_b, vid_b, le_b, fe_b;
    logic [3:0] x_b, y_b;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] fc_a, fc_b;
`endif

    vga_timing_gen u_dut_a (
        .clk      (clk),
        .reset_n  (reset_n),
        .run      (run_a),
`ifdef VGA_FRAME_CNT_EN
        .frame_cnt_clr (1'b0),
        .frame_cnt     (fc_a),
`endif
        .pix_tick (tick_a),
        .h_sync   (hs_a),
        .v_sync   (vs_a),
        .video_on (vid_a),
        .pixel_x  (x_a),
        .pixel_y  (y_a),
        .line_end (le_a),
        .frame_end(fe_a)
    );

    vga_timing_gen #(
        .CLK_DIV (1),
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL  (1'b1),
        .VS_POL  (1'b0),
        .CW      (4)
    ) u_dut_b (
        .clk      (clk),
        .reset_n  (reset_n),
        .run      (run_b),
`ifdef VGA_FRAME_CNT_EN
        .frame_cnt_clr (1'b0),
        .frame_cnt     (fc_b),
`endif
        .pix_tick (tick_b),
        .h_sync   (hs_b),
        .v_sync   (vs_b),
        .video_on (vid_b),
        .pixel_x  (x_b),
        .pixel_y  (y_b),
        .line_end (le_b),
        .frame_end(fe_b)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        longint x;
        longint y;
        longint fc;
        bit     tick;
        bit     hs;
        bit     vs;
        bit     vid;
        bit     le;
        bit     fe;
    } exp_t;

    // Everything follows from the number of enabled clocks since reset.
    function automatic exp_t model(input longint c, input bit run, input int d,
                                   input int ha, input int hf, input int hw, input int hb,
                                   input int va, input int vf, input int vw, input int vb,
                                   input bit hp, input bit vp);
        exp_t e;
        longint ht, vt, t;
        ht = ha + hf + hw + hb;
        vt = va + vf + vw + vb;
        t = c / d;
        e.x = t % ht;
        e.y = (t / ht) % vt;
        e.fc = (t / (ht * vt)) % 65536;
        e.tick = run && ((c % d) == d - 1);
        e.hs = (e.x >= ha + hf && e.x < ha + hf + hw) ? hp : !hp;
        e.vs = (e.y >= va + vf && e.y < va + vf + vw) ? vp : !vp;
        e.vid = (e.x < ha) && (e.y < va);
        e.le = e.tick && (e.x == ht - 1);
        e.fe = e.le && (e.y == vt - 1);
        return e;
    endfunction

    longint ca = 0;
    longint cb = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ca <= 0;
            cb <= 0;
        end else begin
            if (run_a) ca <= ca + 1;
            if (run_b) cb <= cb + 1;
        end
    end

    always @(negedge clk) begin
        exp_t ea, eb;
        if (reset_n) begin
            ea = model(ca, run_a, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
            eb = model(cb, run_b, 1, 4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b0);
            chk("a_x", x_a, ea.x);
            chk("a_y", y_a, ea.y);
            chk("a_tick", tick_a, ea.tick);
            chk("a_hs", hs_a, ea.hs);
            chk("a_vs", vs_a, ea.vs);
            chk("a_vid", vid_a, ea.vid);
            chk("a_le", le_a, ea.le);
            chk("a_fe", fe_a, ea.fe);
            chk("b_x", x_b, eb.x);
            chk("b_y", y_b, eb.y);
            chk("b_tick", tick_b, eb.tick);
            chk("b_hs", hs_b, eb.hs);
            chk("b_vs", vs_b, eb.vs);
            chk("b_vid", vid_b, eb.vid);
            chk("b_le", le_b, eb.le);
            chk("b_fe", fe_b, eb.fe);
`ifdef VGA_FRAME_CNT_EN
            chk("a_fc", fc_a, ea.fc);
            chk("b_fc", fc_b, eb.fc);
`endif
        end
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #1;
        chk("rst_a_x", x_a, 0);
        chk("rst_a_tick", tick_a, 0);
        chk("rst_a_hs", hs_a, 1);
        chk("rst_a_vs", vs_a, 1);
        chk("rst_a_vid", vid_a, 1);
        chk("rst_b_hs", hs_b, 0);
        repeat (2) @(negedge clk);
        #1;
        reset_n = 1'b1;

        edges(4);
        chk("b_x_n4", x_b, 4);
        chk("b_hs_n4", hs_b, 0);
        edges(1);
        chk("b_x_n5", x_b, 5);
        chk("b_hs_n5", hs_b, 1);
        chk("a_x_n5", x_a, 1);
        edges(2);
        chk("b_x_n7", x_b, 7);
        chk("b_le_n7", le_b, 1);
        edges(24);
        chk("b_y_n31", y_b, 3);
        chk("b_vs_n31", vs_b, 1);
        edges(1);
        chk("b_y_n32", y_b, 4);
        chk("b_vs_n32", vs_b, 0);
        edges(15);
        chk("b_x_n47", x_b, 7);
        chk("b_y_n47", y_b, 5);
        chk("b_fe_n47", fe_b, 1);
        edges(1);
        chk("b_x_n48", x_b, 0);
        chk("b_y_n48", y_b, 0);
        chk("b_fe_n48", fe_b, 0);

        edges(2511);
        chk("a_x_n2559", x_a, 639);
        chk("a_vid_n2559", vid_a, 1);
        edges(1);
        chk("a_vid_n2560", vid_a, 0);
        edges(63);
        chk("a_x_n2623", x_a, 655);
        chk("a_hs_n2623", hs_a, 1);
        edges(1);
        chk("a_x_n2624", x_a, 656);
        chk("a_hs_n2624", hs_a, 0);
        edges(383);
        chk("a_x_n3007", x_a, 751);
        chk("a_hs_n3007", hs_a, 0);
        edges(1);
        chk("a_hs_n3008", hs_a, 1);
        edges(191);
        chk("a_x_n3199", x_a, 799);
        chk("a_tick_n3199", tick_a, 1);
        chk("a_le_n3199", le_a, 1);
        edges(1);
        chk("a_x_n3200", x_a, 0);
        chk("a_y_n3200", y_a, 1);
        chk("a_le_n3200", le_a, 0);

        edges(300);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_a_x", x_a, 0);
        chk("arst_a_y", y_a, 0);
        chk("arst_a_tick", tick_a, 0);
        chk("arst_a_hs", hs_a, 1);
        chk("arst_a_vs", vs_a, 1);
        chk("arst_a_vid", vid_a, 1);
        chk("arst_b_tick", tick_b, 1);
        chk("arst_b_hs", hs_b, 0);
        @(negedge clk);
        #1;
        reset_n = 1'b1;

        edges(801);
        chk("frz_x_pre", x_a, 200);
        chk("frz_tick_pre", tick_a, 0);
        run_a = 1'b0;
        edges(37);
        chk("frz_x_hold", x_a, 200);
        chk("frz_tick_hold", tick_a, 0);
        chk("frz_le_hold", le_a, 0);
        run_a = 1'b1;
        edges(2);
        chk("frz_tick_resume", tick_a, 1);
        chk("frz_x_resume", x_a, 200);
        edges(1);
        chk("frz_x_next", x_a, 201);

        for (int i = 0; i < 20000; i++) begin
            @(posedge clk);
            #2;
            run_a = ($urandom % 4) != 0;
            run_b = ($urandom % 3) != 0;
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
